dmem_copy_engine: RTL and testbench

//   Bus initiator for the dmem port: copies a block of 16-bit words from srcAddr to dstAddr,
//   or fills a block at dstAddr with a constant value.

---
 rtl/dmem_copy_engine.sv | 69 ++++++
 tb/tb_dmem_copy_engine.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dmem_copy_engine.sv
// dmem_copy_engine: block copy or constant fill of 16-bit words on the dmem port
module dmem_copy_engine #(
    parameter logic [15:0] ADDR_STEP = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        fillMode,
    input  logic [15:0] srcAddr,
    input  logic [15:0] dstAddr,
    input  logic [15:0] length,
    input  logic [15:0] fillValue,
    output logic        busy,
    output logic        done,
    output logic        memWrite,
    output logic [15:0] address,
    output logic [15:0] writeData,
    input  logic [15:0] readData
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, FILL, DONE} state_t;
    state_t state, next_state;
    logic [15:0] src, dst, count, buffer, fill_value;
    logic        writing;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = !start ? IDLE : length == 16'd0 ? DONE : fillMode ? FILL : READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = count == 16'd1 ? DONE : READ;
            FILL:    next_state = count == 16'd1 ? DONE : FILL;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            src        <= '0;
            dst        <= '0;
            count      <= '0;
            buffer     <= '0;
            fill_value <= '0;
        end else begin
            if (state == IDLE && start) begin
                src        <= srcAddr;
                dst        <= dstAddr;
                count      <= length;
                fill_value <= fillValue;
            end
            if (state == READ) buffer <= readData;
            if (writing) begin
                dst   <= dst + ADDR_STEP;
                count <= count - 16'd1;
            end
            if (state == WRITE) src <= src + ADDR_STEP;
        end
    end
    // reset gates the write strobe so nothing commits at the reset edge
    always_comb begin
        writing   = state == WRITE || state == FILL;
        busy      = state == READ || writing;
        done      = state == DONE;
        memWrite  = writing && !reset;
        address   = state == READ ? src : writing ? dst : 16'd0;
        writeData = state == WRITE ? buffer : state == FILL ? fill_value : 16'd0;
    end
endmodule

// File: tb/tb_dmem_copy_engine.sv
// tb_dmem_copy_engine: table vectors, corner sequences and random ops checked against a word-array model
module tb_dmem_copy_engine;
    logic        clk = 1'b0;
    logic        reset, start, fill_mode;
    logic [15:0] src_addr, dst_addr, length, fill_value;
    logic        busy, done, mem_write;
    logic [15:0] address, write_data, read_data;
    logic [15:0] mem [65536];
    logic [15:0] exp_mem [65536];
    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          fill;
        logic [15:0] src, dst, len, fval;
        int          exp_busy, exp_writes;
    } vec_t;

    dmem_copy_engine dut (
        .clk(clk), .reset(reset), .start(start), .fillMode(fill_mode),
        .srcAddr(src_addr), .dstAddr(dst_addr), .length(length), .fillValue(fill_value),
        .busy(busy), .done(done), .memWrite(mem_write),
        .address(address), .writeData(write_data), .readData(read_data)
    );

    always #5 clk = ~clk;
    assign read_data = mem[address];
    always @(posedge clk) if (mem_write) mem[address] <= write_data;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== exp_mem[i]) bad++;
        check({name, "_mem_mismatches"}, bad, 0);
    endtask

    task automatic run_op(input bit fill, input logic [15:0] src, dst, len, fval,
                          input bit poke, input int exp_busy, exp_writes, input string tag);
        int nb = 0, nw = 0, nd = 0, dc = -1;
        int nc = 2 * int'(len) + 4;
        logic [15:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = dst + 16'(i);
            exp_mem[a] = fill ? fval : exp_mem[src + 16'(i)];
        end
        @(negedge clk);
        fill_mode = fill; src_addr = src; dst_addr = dst; length = len; fill_value = fval; start = 1'b1;
        for (int i = 1; i <= nc; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                fill_mode = 1'($urandom); src_addr = 16'($urandom); dst_addr = 16'($urandom);
                length = 16'($urandom); fill_value = 16'($urandom);
            end
            if (poke && len >= 16'd2) start = (i == 2);
            if (i == 3) start = 1'b0;
            nb += int'(busy);
            nw += int'(mem_write);
            if (done) begin
                nd++;
                if (dc < 0) dc = i;
            end
        end
        check({tag, "_busy_cycles"}, nb, exp_busy);
        check({tag, "_write_cycles"}, nw, exp_writes);
        check({tag, "_done_pulses"}, nd, 1);
        check({tag, "_done_cycle"}, dc, exp_busy + 1);
        check_mem(tag);
    endtask

    initial begin
        vec_t vecs[7];
        int nw, nd;
        bit f;
        logic [15:0] l;
        vecs[0] = '{1'b0, 16'h0010, 16'h0040, 16'd4, 16'h0000, 8, 4};
        vecs[1] = '{1'b1, 16'h0000, 16'h0080, 16'd3, 16'hBEEF, 3, 3};
        vecs[2] = '{1'b0, 16'h0060, 16'h0070, 16'd0, 16'h0000, 0, 0};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFE, 16'd4, 16'h1234, 4, 4};
        vecs[4] = '{1'b0, 16'h0100, 16'h0102, 16'd4, 16'h0000, 8, 4};
        vecs[5] = '{1'b0, 16'h0120, 16'h0120, 16'd3, 16'h0000, 6, 3};
        vecs[6] = '{1'b0, 16'hFFFE, 16'h0500, 16'd3, 16'h0000, 6, 3};
        for (int i = 0; i < 65536; i++) exp_mem[i] = 16'($urandom);
        exp_mem[16'h10] = 16'hA1; exp_mem[16'h11] = 16'hB2;
        exp_mem[16'h12] = 16'hC3; exp_mem[16'h13] = 16'hD4;
        for (int i = 0; i < 65536; i++) mem[i] <= exp_mem[i];
        reset = 1'b1; start = 1'b0; fill_mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_memwrite", int'(mem_write), 0);
        check("rst_address", int'(address), 0);
        check("rst_writedata", int'(write_data), 0);
        for (int v = 0; v < 7; v++)
            run_op(vecs[v].fill, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fval,
                   1'b0, vecs[v].exp_busy, vecs[v].exp_writes, $sformatf("vec%0d", v));
        check("copy_word0", int'(mem[16'h40]), 16'hA1);
        check("copy_word3", int'(mem[16'h43]), 16'hD4);
        // second start while busy must not launch another transfer
        run_op(1'b0, 16'h0010, 16'h0900, 16'd4, 16'h0, 1'b1, 8, 4, "poke_copy");
        run_op(1'b1, 16'h0000, 16'h0A00, 16'd5, 16'h5A5A, 1'b1, 5, 5, "poke_fill");
        // reset in the third WRITE of a 5-word copy leaves two words copied
        for (int i = 0; i < 2; i++) exp_mem[16'h0300 + 16'(i)] = exp_mem[16'h0200 + 16'(i)];
        @(negedge clk);
        fill_mode = 1'b0; src_addr = 16'h0200; dst_addr = 16'h0300; length = 16'd5; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrst_in_write", int'(mem_write), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_memwrite", int'(mem_write), 0);
        check("midrst_busy", int'(busy), 0);
        reset = 1'b0;
        nw = 0; nd = 0;
        repeat (6) begin
            @(negedge clk);
            nw += int'(mem_write);
            nd += int'(done);
        end
        check("midrst_no_writes", nw, 0);
        check("midrst_no_done", nd, 0);
        check_mem("midrst");
        run_op(1'b0, 16'h0200, 16'h0300, 16'd5, 16'h0, 1'b0, 10, 5, "after_rst");
        for (int r = 0; r < 10; r++) begin
            f = 1'($urandom);
            l = 16'($urandom_range(0, 12));
            run_op(f, 16'($urandom), 16'($urandom), l, 16'($urandom), 1'($urandom),
                   f ? int'(l) : 2 * int'(l), int'(l), $sformatf("rnd%0d", r));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
